// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions used by the hazard unit: the mul/div state encoding,
// the register-0 number and the layout of the MEM control bundle.
package hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MEM control bundle: {MemRead, MemWrite}
  localparam int MEM_CTRL_W   = 2;
  localparam int MEM_READ_BIT = 1;

endpackage

// File: rtl/hazard_ctrl_muldiv_timer.sv
// Multiply/divide occupancy timer: two-state FSM with a 5-bit down-counter and a
// registered one-cycle completion pulse.
module hazard_muldiv_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [4:0] CNT_LOAD = 5'(MULDIV_LAT - 1);

  md_state_t  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        // CNT reaching zero ends the occupancy; the pulse lands on the first IDLE cycle
        if (cnt_q == 5'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  assign busy = (state_q == BUSY);
  assign done = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use detection, branch flush, mul/div occupancy stall
// and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_MulDivStart,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_DestReg,
  input  logic        EX_BranchTaken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic [15:0] StallCycles
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic load_use;
  logic md_start;
  logic md_busy;
  logic [15:0] stall_q;

  assign load_use = EX_MemRead & (EX_DestReg != REG_ZERO) &
                    ((EX_DestReg == ID_Rs) | (ID_UsesRt & (EX_DestReg == ID_Rt)));

  // A new mult/div is only accepted when the instruction in ID is actually advancing
  assign md_start = ID_MulDivStart & ~load_use & ~EX_BranchTaken & ~md_busy & ~Reset;

  hazard_muldiv_timer #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_timer (
    .Clk  (Clk),
    .Reset(Reset),
    .start(md_start),
    .busy (md_busy),
    .done (MulDivDone)
  );

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    if (Reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (md_busy || load_use) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_q <= 16'd0;
    end else if (!PCWrite) begin
      stall_q <= sat_inc16(stall_q);
    end
  end

  assign MulDivBusy  = md_busy;
  assign StallCycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MULDIV_LAT=8: hazard outputs, mul/div timing,
// reset abort and stall-counter saturation.
module tb_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_DestReg;
  logic        ID_UsesRt, ID_MulDivStart, EX_MemRead, EX_BranchTaken;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
  logic        MulDivBusy, MulDivDone;
  logic [15:0] StallCycles;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl #(.MULDIV_LAT(8)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ID_Rs         (ID_Rs),
    .ID_Rt         (ID_Rt),
    .ID_UsesRt     (ID_UsesRt),
    .ID_MulDivStart(ID_MulDivStart),
    .EX_MemRead    (EX_MemRead),
    .EX_DestReg    (EX_DestReg),
    .EX_BranchTaken(EX_BranchTaken),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .ID_EX_Bubble  (ID_EX_Bubble),
    .MulDivBusy    (MulDivBusy),
    .MulDivDone    (MulDivDone),
    .StallCycles   (StallCycles)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_in();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_MulDivStart = 1'b0;
    EX_MemRead = 1'b0; EX_DestReg = 5'd0; EX_BranchTaken = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    clear_in();
    tick();
    tick();
    // reset state
    chk_ctl("reset_ctl", 4'b0011);
    chk("reset_busy", {31'd0, MulDivBusy}, 32'd0);
    chk("reset_done", {31'd0, MulDivDone}, 32'd0);
    chk("reset_stall", {16'd0, StallCycles}, 32'd0);

    Reset = 1'b0;
    #1;
    chk_ctl("normal_ctl", 4'b1100);
    tick();
    chk("normal_stall", {16'd0, StallCycles}, 32'd0);

    // load-use through Rs
    EX_MemRead = 1'b1; EX_DestReg = 5'd5; ID_Rs = 5'd5;
    #1;
    chk_ctl("lu_rs_ctl", 4'b0001);
    tick();
    chk("lu_rs_stall", {16'd0, StallCycles}, 32'd1);
    clear_in();
    #1;
    chk_ctl("lu_clear_ctl", 4'b1100);
    tick();
    chk("lu_clear_stall", {16'd0, StallCycles}, 32'd1);

    // register 0 never hazards
    EX_MemRead = 1'b1; EX_DestReg = 5'd0; ID_Rs = 5'd0;
    #1;
    chk_ctl("lu_r0_ctl", 4'b1100);
    tick();
    // Rt match ignored when Rt is not read
    EX_DestReg = 5'd7; ID_Rt = 5'd7; ID_Rs = 5'd3; ID_UsesRt = 1'b0;
    #1;
    chk_ctl("lu_rt_unused_ctl", 4'b1100);
    tick();
    chk("no_stall_stall", {16'd0, StallCycles}, 32'd1);
    ID_UsesRt = 1'b1;
    #1;
    chk_ctl("lu_rt_used_ctl", 4'b0001);
    tick();
    chk("lu_rt_stall", {16'd0, StallCycles}, 32'd2);

    // branch overrides load-use
    clear_in();
    EX_MemRead = 1'b1; EX_DestReg = 5'd5; ID_Rs = 5'd5; EX_BranchTaken = 1'b1;
    #1;
    chk_ctl("br_lu_ctl", 4'b1111);
    tick();
    chk("br_lu_stall", {16'd0, StallCycles}, 32'd2);

    // mult/div start blocked by branch, then by load-use
    ID_MulDivStart = 1'b1;
    tick();
    chk("start_br_busy", {31'd0, MulDivBusy}, 32'd0);
    EX_BranchTaken = 1'b0;
    tick();
    chk("start_lu_busy", {31'd0, MulDivBusy}, 32'd0);
    chk("start_lu_stall", {16'd0, StallCycles}, 32'd3);

    // accepted mult/div: 8 busy cycles, start held high is ignored
    clear_in();
    ID_MulDivStart = 1'b1;
    #1;
    chk_ctl("md_accept_ctl", 4'b1100);
    tick();
    for (int i = 0; i < 8; i++) begin
      ID_MulDivStart = (i < 7);
      #1;
      chk("md_busy", {31'd0, MulDivBusy}, 32'd1);
      chk("md_done_early", {31'd0, MulDivDone}, 32'd0);
      chk_ctl("md_busy_ctl", 4'b0001);
      tick();
    end
    ID_MulDivStart = 1'b0;
    #1;
    chk("md_end_busy", {31'd0, MulDivBusy}, 32'd0);
    chk("md_done", {31'd0, MulDivDone}, 32'd1);
    chk_ctl("md_end_ctl", 4'b1100);
    chk("md_stall", {16'd0, StallCycles}, 32'd11);
    tick();
    chk("md_done_once", {31'd0, MulDivDone}, 32'd0);

    // branch during busy flushes but does not abort
    ID_MulDivStart = 1'b1;
    tick();
    ID_MulDivStart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      EX_BranchTaken = (i == 2);
      #1;
      chk("mdbr_busy", {31'd0, MulDivBusy}, 32'd1);
      chk_ctl("mdbr_ctl", (i == 2) ? 4'b1111 : 4'b0001);
      tick();
    end
    EX_BranchTaken = 1'b0;
    #1;
    chk("mdbr_done", {31'd0, MulDivDone}, 32'd1);
    chk("mdbr_stall", {16'd0, StallCycles}, 32'd18);
    tick();

    // reset on the third busy cycle abandons the operation
    ID_MulDivStart = 1'b1;
    tick();
    ID_MulDivStart = 1'b0;
    tick();
    tick();
    chk("rst_mid_stall_pre", {16'd0, StallCycles}, 32'd20);
    Reset = 1'b1;
    #1;
    chk_ctl("rst_mid_ctl", 4'b0011);
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, MulDivBusy}, 32'd0);
    chk("rst_mid_done", {31'd0, MulDivDone}, 32'd0);
    chk("rst_mid_stall", {16'd0, StallCycles}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_mid_no_done", {30'd0, MulDivDone, MulDivBusy}, 32'd0);
    end

    // saturation under a persistent load-use hazard
    EX_MemRead = 1'b1; EX_DestReg = 5'd9; ID_Rs = 5'd9;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", {16'd0, StallCycles}, 32'h0000FFFE);
    tick();
    chk("sat_ffff", {16'd0, StallCycles}, 32'h0000FFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", {16'd0, StallCycles}, 32'h0000FFFF);
    clear_in();
    tick();
    chk("sat_release", {16'd0, StallCycles}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULDIV_LAT, default 8, multiply/divide occupancy in cycles; legal range 2..32.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 ID_Rs / ID_Rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 ID_UsesRt  input  1  high when the ID instruction reads Rt.
REQ-006 ID_MulDivStart  input  1  high when the ID instruction is mult/div.
REQ-007 EX_MemRead  input  1  MemRead bit taken from the EX-side MEM control bundle.
REQ-008 EX_DestReg  input  5  destination register selected in EX (after RegDst mux).
REQ-009 EX_BranchTaken  input  1  branch resolved taken in EX this cycle.
REQ-010 PCWrite  output  1  PC update enable.
REQ-011 IF_ID_Write  output  1  IF/ID register load enable.
REQ-012 IF_ID_Flush  output  1  zero the IF/ID register on the next edge.
REQ-013 ID_EX_Bubble  output  1  force all ID/EX control fields (WB, MEM, EX) to zero on the next edge.
REQ-014 MulDivBusy  output  1  unit occupied.
REQ-015 MulDivDone  output  1  one-cycle pulse when the result is valid.
REQ-016 StallCycles  output  16  saturating count of stall cycles.

Function
REQ-017 States: IDLE and BUSY, 1-bit state register; down-counter CNT, 5 bits.
REQ-018 LoadUse = EX_MemRead & (EX_DestReg != 0) & ((EX_DestReg == ID_Rs) | (ID_UsesRt & (EX_DestReg == ID_Rt))).
REQ-019 PCWrite, IF_ID_Write, IF_ID_Flush and ID_EX_Bubble are combinational in the same cycle as their causes; there are no registered hazard outputs.
REQ-020 Priority when not in reset: EX_BranchTaken, then BUSY, then LoadUse, then normal.
REQ-021 EX_BranchTaken: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, IF_ID_Write=1 (the PC loads the target).
REQ-022 State BUSY without a branch: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
REQ-023 LoadUse in IDLE without a branch: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0 for exactly that cycle.
REQ-024 Normal operation: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0.
REQ-025 IDLE->BUSY on an edge where ID_MulDivStart=1, LoadUse=0 and EX_BranchTaken=0; on that edge CNT loads MULDIV_LAT-1.
REQ-026 In BUSY, CNT decrements each cycle; when CNT==0, MulDivDone=1 (registered, visible the following cycle) and the next state is IDLE.
REQ-027 Total stall from a MulDivStart acceptance is exactly MULDIV_LAT cycles.
REQ-028 MulDivBusy = (state == BUSY).
REQ-029 ID_MulDivStart is ignored while in BUSY or while a branch/LoadUse condition is present in the same cycle.
REQ-030 EX_BranchTaken during BUSY does not abort the operation; the flush is applied and BUSY continues.
REQ-031 StallCycles increments on each edge where PCWrite=0 and not in reset, and saturates at 16'hFFFF.
REQ-032 All of REQ-018..REQ-031 are width-exact; no X propagation when inputs are known.

Reset
REQ-033 While Reset=1: state=IDLE, CNT=0, MulDivDone=0, StallCycles=0, MulDivBusy=0.
REQ-034 While Reset=1, combinational outputs are PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1.
REQ-035 Reset asserted mid-BUSY abandons the operation with no MulDivDone pulse.

Structure
REQ-036 A shared pipeline package holds the state encoding (IDLE=0, BUSY=1), register 0 constant, and the MEM-control MemRead bit index.
REQ-037 A single sub-module, hazard_muldiv_timer, holds the state, CNT, and MulDivDone logic; top-level hazard detection stays flat.

Verification
REQ-038 EX_MemRead=1, EX_DestReg=5, ID_Rs=5 -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for one cycle; StallCycles 0->1.
REQ-039 EX_MemRead=1, EX_DestReg=0, ID_Rs=0 -> no stall; also EX_DestReg=7, ID_Rt=7, ID_UsesRt=0 -> no stall.
REQ-040 ID_MulDivStart=1 with MULDIV_LAT=8 -> MulDivBusy high 8 cycles, MulDivDone pulses once on the cycle after, StallCycles=8.
REQ-041 EX_BranchTaken=1 together with LoadUse=1 -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1; StallCycles unchanged.
REQ-042 Reset asserted on the 3rd BUSY cycle -> next cycle IDLE, no MulDivDone, StallCycles=0.
REQ-043 Force 65540 stall cycles -> StallCycles holds at 16'hFFFF.
